// File: rtl/legv8_pipe_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// legv8_pipe_pkg: shared types and constants for the LEGv8 MEM stage.
// Rev 1.0
// ----------------------------------------------------------------------------
package legv8_pipe_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

    localparam logic [2:0] ALIGN_MASK = 3'b111;
    localparam int         REG_W      = 5;

    // Doubleword accesses must sit on an 8-byte boundary.
    function automatic logic addr_aligned(input logic [2:0] low_bits);
        return (low_bits & ALIGN_MASK) == 3'b000;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wb_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_wb_pipe: MEM/WB pipeline register; a bubble load zeroes every field.
// Rev 1.0
// ----------------------------------------------------------------------------
module mem_wb_pipe
    import legv8_pipe_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              bubble,
    input  logic              reg_write,
    input  logic              mem2reg,
    input  logic [DATA_W-1:0] read_data,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [REG_W-1:0]  write_reg,
    output logic              regWrite_wb,
    output logic              mem2Reg_wb,
    output logic [DATA_W-1:0] read_data_wb,
    output logic [DATA_W-1:0] alu_result_wb,
    output logic [REG_W-1:0]  write_reg_wb
);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            regWrite_wb   <= 1'b0;
            mem2Reg_wb    <= 1'b0;
            read_data_wb  <= '0;
            alu_result_wb <= '0;
            write_reg_wb  <= '0;
        end else if (bubble) begin
            regWrite_wb   <= 1'b0;
            mem2Reg_wb    <= 1'b0;
            read_data_wb  <= '0;
            alu_result_wb <= '0;
            write_reg_wb  <= '0;
        end else begin
            regWrite_wb   <= reg_write;
            mem2Reg_wb    <= mem2reg;
            read_data_wb  <= read_data;
            alu_result_wb <= alu_result;
            write_reg_wb  <= write_reg;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_stage_unit: LEGv8 MEM stage - branch resolve, data-memory handshake, MEM/WB.
// Rev 1.0
// ----------------------------------------------------------------------------
module mem_stage_unit
    import legv8_pipe_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ZeroBranch_in,
    input  logic              UnconBranch_in,
    input  logic              memRead_in,
    input  logic              memWrite_in,
    input  logic              regWrite_in,
    input  logic              mem2Reg_in,
    input  logic              alu_zero_in,
    input  logic [DATA_W-1:0] shifted_PC_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] write_data_mem_in,
    input  logic [REG_W-1:0]  write_reg_in,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic              stall,
    output logic              PCSrc,
    output logic [DATA_W-1:0] branch_target,
    output logic              mem_error,
    output logic              regWrite_wb,
    output logic              mem2Reg_wb,
    output logic [DATA_W-1:0] read_data_wb,
    output logic [DATA_W-1:0] alu_result_wb,
    output logic [REG_W-1:0]  write_reg_wb
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    mem_state_t        state;
    mem_state_t        state_next;
    logic [CNT_W-1:0]  wait_cnt;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              we_q;
    logic              reg_write_q;
    logic              mem2reg_q;
    logic [REG_W-1:0]  write_reg_q;
    logic              op_err_q;
    logic              mem_error_q;

    logic              mem_op;
    logic              aligned;
    logic              illegal;
    logic              timeout_hit;
    logic              stall_fsm;
    logic              req_fsm;
    logic              start;
    logic              misalign;
    logic              abort;
    logic              wb_reg_write;
    logic              wb_mem2reg;
    logic [DATA_W-1:0] wb_read_data;
    logic [DATA_W-1:0] wb_alu_result;
    logic [REG_W-1:0]  wb_write_reg;

    assign mem_op      = memRead_in | memWrite_in;
    assign aligned     = addr_aligned(alu_result_in[2:0]);
    assign illegal     = memRead_in & memWrite_in;
    // wait_cnt holds the number of ACCESS cycles already spent without an ack.
    assign timeout_hit = (TIMEOUT != 0) && ((int'(wait_cnt) + 1) == TIMEOUT);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        stall_fsm     = 1'b0;
        req_fsm       = 1'b0;
        start         = 1'b0;
        misalign      = 1'b0;
        abort         = 1'b0;
        wb_reg_write  = regWrite_in;
        wb_mem2reg    = mem2Reg_in;
        wb_read_data  = '0;
        wb_alu_result = alu_result_in;
        wb_write_reg  = write_reg_in;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    if (aligned) begin
                        stall_fsm  = 1'b1;
                        start      = 1'b1;
                        state_next = ACCESS;
                    end else begin
                        misalign     = 1'b1;
                        wb_reg_write = 1'b0;
                    end
                end
            end
            ACCESS: begin
                stall_fsm = 1'b1;
                req_fsm   = 1'b1;
                if (dmem_ack) begin
                    state_next = DONE;
                end else if (timeout_hit) begin
                    abort      = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                wb_reg_write  = reg_write_q & ~op_err_q;
                wb_mem2reg    = mem2reg_q;
                wb_read_data  = rdata_q;
                wb_alu_result = addr_q;
                wb_write_reg  = write_reg_q;
                state_next    = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wait_cnt    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            we_q        <= 1'b0;
            reg_write_q <= 1'b0;
            mem2reg_q   <= 1'b0;
            write_reg_q <= '0;
            op_err_q    <= 1'b0;
            mem_error_q <= 1'b0;
        end else begin
            if (start) begin
                wait_cnt    <= '0;
                addr_q      <= alu_result_in;
                wdata_q     <= write_data_mem_in;
                rdata_q     <= '0;
                we_q        <= memWrite_in;
                reg_write_q <= regWrite_in;
                mem2reg_q   <= mem2Reg_in;
                write_reg_q <= write_reg_in;
                op_err_q    <= illegal;
            end else if (state == ACCESS) begin
                if (dmem_ack) begin
                    if (!we_q) begin
                        rdata_q <= dmem_rdata;
                    end
                end else begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                    if (abort) begin
                        op_err_q <= 1'b1;
                    end
                end
            end
            if (misalign || (start && illegal) || abort) begin
                mem_error_q <= 1'b1;
            end
        end
    end

    // Combinational outputs are masked by RESET so they drop the moment it rises.
    assign stall         = stall_fsm & ~RESET;
    assign dmem_req      = req_fsm & ~RESET;
    assign PCSrc         = (UnconBranch_in | (ZeroBranch_in & alu_zero_in)) & ~stall_fsm & ~RESET;
    assign branch_target = RESET ? '0 : shifted_PC_in;
    assign dmem_we       = we_q;
    assign dmem_addr     = addr_q;
    assign dmem_wdata    = wdata_q;
    assign mem_error     = mem_error_q;

    mem_wb_pipe #(
        .DATA_W (DATA_W)
    ) u_mem_wb (
        .CLK           (CLK),
        .RESET         (RESET),
        .bubble        (stall),
        .reg_write     (wb_reg_write),
        .mem2reg       (wb_mem2reg),
        .read_data     (wb_read_data),
        .alu_result    (wb_alu_result),
        .write_reg     (wb_write_reg),
        .regWrite_wb   (regWrite_wb),
        .mem2Reg_wb    (mem2Reg_wb),
        .read_data_wb  (read_data_wb),
        .alu_result_wb (alu_result_wb),
        .write_reg_wb  (write_reg_wb)
    );

endmodule
`default_nettype wire
